instr_mem: RTL and testbench
============================

# instr_mem

Parametrised, writable instruction memory for the RV32I core's fetch stage. It replaces the fixed address-decoded program table with a DEPTH-word synchronous RAM. A boot-time clear engine fills the RAM with NOPs, and a load port lets the testbench or boot loader program it. Fetches use a req/valid handshake with one-cycle latency, misalignment and range checking, and a fault flag for the pipeline.

## Interface
- DEPTH, 64: number of 32-bit words; must be a power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- NOP_WORD, 32'h0000_0013: value used for clear fill and faulted fetches (`addi x0,x0,0`).
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; sampled only when fetch_ready=1.
- fetch_addr  in  32  byte address of the instruction.
- fetch_ready  out  1  memory accepts fetches (state READY).
- fetch_valid  out  1  fetch_instr/fetch_fault are valid this cycle.
- fetch_instr  out  32  fetched word.
- fetch_fault  out  1  the accepted fetch was misaligned or out of range.
- load_we  in  1  write strobe; honoured only in READY.
- load_addr  in  32  byte address of the word to write.
- load_data  in  32  word to write.
- load_err  out  1  one-cycle pulse: a rejected write (misaligned, out of range, or not READY).

## Operation
- **States: CLEAR → READY.**
  - Reset forces CLEAR with clear counter = 0.
  - In CLEAR, one word per cycle is written with NOP_WORD. After word DEPTH-1 is written, the next state is READY.
  - READY is held until the next reset.
- **Index computation:** idx = (addr − BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
  - Misaligned: addr[1:0] ≠ 0.
  - Out of range: addr < BASE_ADDR, or idx ≥ DEPTH.
- **Fetch accept:** an accepted fetch is fetch_req & fetch_ready.
  - Good fetch: fetch_instr = mem[idx], fetch_fault = 0.
  - Faulty fetch: fetch_instr = NOP_WORD, fetch_fault = 1.
- **No accepted fetch:** fetch_valid = 0, and fetch_instr/fetch_fault hold their last values.
- **Load:** a write commits at the clock edge when load_we=1, the state is READY, and the address is legal. Otherwise load_err pulses for one cycle and memory is unchanged.
- **Same-cycle fetch and load to the same index:** read-first. The fetch returns the old word, and the new word is visible from the next fetch onward.
- **load_we during CLEAR:** rejected with load_err. The clear sequence is not disturbed.
- **Reset mid-CLEAR or mid-operation:** the clear restarts at word 0. Any in-flight fetch result is discarded (fetch_valid = 0 next cycle).

## Timing
- **Reset values:**
  - fetch_ready = 0
  - fetch_valid = 0
  - fetch_instr = NOP_WORD
  - fetch_fault = 0
  - load_err = 0
- **Fetch latency:** 1 cycle. A request accepted at edge N drives fetch_valid=1 in the cycle after edge N+1.
- **Throughput:** one fetch per cycle. Back-to-back requests produce back-to-back valid outputs.
- **fetch_ready** rises exactly DEPTH cycles after the cycle in which rst is deasserted.
- **load_err** is registered: it asserts in the cycle after the offending load_we.

## Configuration
- **IMEM_PARITY_EN defined:**
  - Each word stores an extra even-parity bit, computed on write (both clear and load).
  - On fetch, a parity mismatch forces fetch_fault=1 and fetch_instr=NOP_WORD.
  - An extra input port `load_par_flip` (in, 1) inverts the stored parity bit on a load, for error injection.
- **IMEM_PARITY_EN undefined:** no parity storage, no `load_par_flip` port, and the fault is address-based only.

## Structure
- **Shared package `imem_pkg`:**
  - `localparam logic [31:0] RV_NOP = 32'h0000_0013`
  - state enum `imem_state_e {IMEM_CLEAR, IMEM_READY}`
  - function `imem_addr_ok(addr, base, depth)`, returning legal/index
- **Sub-module `imem_ram`:** single-clock, one-write/one-read, read-first synchronous RAM, DEPTH × (32 or 33) bits. instr_mem holds the FSM, address checks and output registers.

## Test plan
- Reset, then poll fetch_ready. With DEPTH=64, fetch_ready=1 exactly 64 cycles after rst falls, and fetches of 0x0/0xFC during CLEAR get no fetch_valid.
- Load 0x00100093 at 4 and 0x00200113 at 8, then fetch 4, 8, 12 back-to-back. Expect valid on three consecutive cycles with 0x00100093, 0x00200113, 0x00000013, fault = 0.
- Fetch 0x6 and 0x100. Expect fetch_fault = 1 and fetch_instr = 0x00000013. Load to 0x102 → load_err pulse and memory unchanged.
- Same cycle: load 0x404284B3 to 56 and fetch 56. The fetch returns the old value; the next fetch of 56 returns 0x404284B3.
- Assert rst for 1 cycle mid-CLEAR (after 20 words), and separately after loading. fetch_ready drops and the full 64-cycle clear is redone. Previously loaded words read back 0x00000013.
- IMEM_PARITY_EN: load 0x00908293 to 36 with load_par_flip=1, then fetch 36. Expect fetch_fault = 1 and fetch_instr = 0x00000013. Reload with flip=0, then fetch 36: returns 0x00908293, fault = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types, constants and address-check helper for the instruction memory.
package imem_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    IMEM_CLEAR,
    IMEM_READY
  } imem_state_e;

  // Result of an address check: legality plus the full 32-bit word index.
  typedef struct packed {
    logic        ok;
    logic [31:0] idx;
  } imem_chk_t;

  // Word-aligned, not below base, and within depth words of base.
  function automatic imem_chk_t imem_addr_ok(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int unsigned depth);
    imem_chk_t   r;
    logic [31:0] off;
    off   = addr - base;
    r.idx = off >> 2;
    r.ok  = (addr[1:0] == 2'b00) && (addr >= base) && (r.idx < depth);
    return r;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-clock, one-write/one-read synchronous RAM. Read-first: a read and a
// write to the same word at the same edge return the old contents.
module imem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; NBA ordering gives read-first.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Writable instruction memory for the fetch stage: boot-time NOP clear,
// load port, and a req/valid fetch port with address fault reporting.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity plus
// load_par_flip error-injection input).
module instr_mem
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic        load_par_flip,
`endif
  output logic        load_err
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int unsigned W = 33;
`else
  localparam int unsigned W = 32;
`endif

  imem_state_e   state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          acc_q, acc_fault_q;
  logic          valid_q, fault_q, load_err_q;
  logic [31:0]   instr_q;

  imem_chk_t     fchk, lchk;
  logic          ready, accept, load_ok, bad;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [W-1:0]  ram_wdata, ram_rdata, nop_entry, load_entry;

  assign fchk    = imem_addr_ok(fetch_addr, BASE_ADDR, DEPTH);
  assign lchk    = imem_addr_ok(load_addr, BASE_ADDR, DEPTH);
  assign ready   = (state_q == IMEM_READY);
  assign accept  = fetch_req & ready;
  assign load_ok = load_we & ready & lchk.ok;

  // Upper index bits only matter through the range check inside the helper.
  logic unused_idx;
  assign unused_idx = ^{fchk.idx[31:AW], lchk.idx[31:AW]};

`ifdef IMEM_PARITY_EN
  assign nop_entry  = {^NOP_WORD, NOP_WORD};
  assign load_entry = {(^load_data) ^ load_par_flip, load_data};
  // Stored bit makes the 33-bit word even; any odd total is corruption.
  assign bad        = acc_fault_q | (^ram_rdata);
`else
  assign nop_entry  = NOP_WORD;
  assign load_entry = load_data;
  assign bad        = acc_fault_q;
`endif

  // Write-port mux: clear engine owns the RAM until READY, then the load port.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_cnt_q;
    ram_wdata = nop_entry;
    if (!rst) begin
      if (!ready) begin
        ram_we = 1'b1;
      end else if (load_ok) begin
        ram_we    = 1'b1;
        ram_waddr = lchk.idx[AW-1:0];
        ram_wdata = load_entry;
      end
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (fchk.idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  // FSM, fetch pipeline (accept stage then output stage) and load error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IMEM_CLEAR;
      clr_cnt_q   <= '0;
      acc_q       <= 1'b0;
      acc_fault_q <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= NOP_WORD;
      fault_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      if (state_q == IMEM_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_q <= IMEM_READY;
      end
      acc_q       <= accept;
      acc_fault_q <= ~fchk.ok;
      valid_q     <= acc_q;
      if (acc_q) begin
        instr_q <= bad ? NOP_WORD : ram_rdata[31:0];
        fault_q <= bad;
      end
      load_err_q <= load_we & ~(ready & lchk.ok);
    end
  end

  assign fetch_ready = ready;
  assign fetch_valid = valid_q;
  assign fetch_instr = instr_q;
  assign fetch_fault = fault_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: behavioural model plus directed literals.
module tb_instr_mem;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready, fetch_valid, fetch_fault, load_err;
  logic [31:0] fetch_instr;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_par_flip = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_mem #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .NOP_WORD  (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_fault   (fetch_fault),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip (load_par_flip),
`endif
    .load_err      (load_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned due;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem  [DEPTH];
  bit          bad  [DEPTH];
  int unsigned cyc = 0, last_rst = 0;
  bit          started = 0, m_ready = 0, exp_err = 0;
  logic [31:0] held_instr = NOP;
  logic        held_fault = 1'b0;
  int          n_valid = 0;

  logic [31:0] got_instr[$];
  logic        got_fault[$];
  int unsigned got_cyc[$];

  function automatic bit legal(input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    return (la % 4 == 0) && (la >= lb) && ((la - lb) / 4 < longint'(DEPTH));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  // Model update from the inputs sampled at this edge, then compare outputs.
  always @(posedge clk) begin
    exp_t e;
    bit   ev;
    #1;
    cyc++;
    if (rst) begin
      started  = 1;
      last_rst = cyc;
      m_ready  = 0;
      exp_err  = 0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = NOP;
        bad[i] = 0;
      end
      held_instr = NOP;
      held_fault = 1'b0;
      n_valid    = 0;
    end else if (started) begin
      if (fetch_req && m_ready) begin
        e.due = cyc + 1;
        if (legal(fetch_addr) && !bad[widx(fetch_addr)]) begin
          e.instr = mem[widx(fetch_addr)];
          e.fault = 1'b0;
        end else begin
          e.instr = NOP;
          e.fault = 1'b1;
        end
        exp_q.push_back(e);
      end
      exp_err = load_we && !(m_ready && legal(load_addr));
      if (load_we && m_ready && legal(load_addr)) begin
        mem[widx(load_addr)] = load_data;
`ifdef IMEM_PARITY_EN
        bad[widx(load_addr)] = load_par_flip;
`else
        bad[widx(load_addr)] = 0;
`endif
      end
      m_ready = (cyc - last_rst) >= DEPTH;
    end
    if (started) begin
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("fetch_ready", fetch_ready, m_ready);
      chk("load_err", load_err, exp_err);
      chk("fetch_valid", fetch_valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        held_instr = e.instr;
        held_fault = e.fault;
      end
      chk("fetch_instr", fetch_instr, held_instr);
      chk("fetch_fault", fetch_fault, held_fault);
      if (fetch_valid) begin
        n_valid++;
        got_instr.push_back(fetch_instr);
        got_fault.push_back(fetch_fault);
        got_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic req, input logic [31:0] fa, input logic we,
                       input logic [31:0] la, input logic [31:0] ld, input logic flip);
    @(negedge clk);
    fetch_req     = req;
    fetch_addr    = fa;
    load_we       = we;
    load_addr     = la;
    load_data     = ld;
    load_par_flip = flip;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_req = 1'b0;
    load_we   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts edges from reset release to fetch_ready while poking fetches and
  // out-of-range loads, which must all be refused during the clear.
  task automatic wait_ready(input string name);
    int k = 0;
    while (!fetch_ready && k < 200) begin
      drive(1'b1, k[0] ? 32'h0 : 32'hFC, 1'b1, 32'h200, 32'h1234_5678, 1'b0);
      k++;
    end
    chk({name, "_ready_latency"}, k, DEPTH);
    chk({name, "_no_valid_in_clear"}, n_valid, 0);
    idle(1);
  endtask

  task automatic clear_got();
    got_instr.delete();
    got_fault.delete();
    got_cyc.delete();
  endtask

  task automatic check_got(input string name, input int i, input logic [31:0] ei,
                           input logic ef);
    if (i >= got_instr.size()) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      chk({name, "_instr"}, got_instr[i], ei);
      chk({name, "_fault"}, got_fault[i], ef);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: a = BASE + 4 * $urandom_range(0, 15);
      5:             a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      6:             a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      7:             a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 7);
      8:             a = $urandom();
      default:       a = BASE + 4 * (DEPTH - 1);
    endcase
    return a;
  endfunction

  initial begin
    do_reset();
    wait_ready("boot");

    // Loads then back-to-back fetches.
    drive(1'b0, 32'h0, 1'b1, 32'h4, 32'h0010_0093, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h8, 32'h0020_0113, 1'b0);
    clear_got();
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check_got("b2b0", 0, 32'h0010_0093, 1'b0);
    check_got("b2b1", 1, 32'h0020_0113, 1'b0);
    check_got("b2b2", 2, 32'h0000_0013, 1'b0);
    if (got_cyc.size() == 3) chk("b2b_consecutive", got_cyc[2] - got_cyc[0], 2);
    else chk("b2b_count", got_cyc.size(), 3);

    // Faulting fetches and a rejected load.
    clear_got();
    drive(1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check_got("misalign", 0, 32'h0000_0013, 1'b1);
    check_got("range", 1, 32'h0000_0013, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h102, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #2;
    chk("load_err_pulse", load_err, 1);
    idle(1);
    @(posedge clk); #2;
    chk("load_err_drop", load_err, 0);
    clear_got();
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check_got("unchanged", 0, 32'h0010_0093, 1'b0);

    // Same-cycle load and fetch: read-first.
    clear_got();
    drive(1'b1, 32'd56, 1'b1, 32'd56, 32'h4042_84B3, 1'b0);
    drive(1'b1, 32'd56, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check_got("rf_old", 0, 32'h0000_0013, 1'b0);
    check_got("rf_new", 1, 32'h4042_84B3, 1'b0);

    // Reset mid-clear, then reset after loading.
    do_reset();
    idle(20);
    do_reset();
    wait_ready("midclear");
    do_reset();
    wait_ready("postload");
    clear_got();
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'd56, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check_got("wiped4", 0, 32'h0000_0013, 1'b0);
    check_got("wiped56", 1, 32'h0000_0013, 1'b0);

`ifdef IMEM_PARITY_EN
    clear_got();
    drive(1'b0, 32'h0, 1'b1, 32'd36, 32'h0090_8293, 1'b1);
    drive(1'b1, 32'd36, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'd36, 32'h0090_8293, 1'b0);
    drive(1'b1, 32'd36, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check_got("par_bad", 0, 32'h0000_0013, 1'b1);
    check_got("par_good", 1, 32'h0090_8293, 1'b0);
`endif

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 2) == 0),
                 rand_addr(), $urandom(), 1'($urandom_range(0, 7) == 0));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
